// File: rtl/core_host_pkg.sv
// rtl/core_host_pkg.sv - shared state encoding and instruction bit offsets for the host sequencer
package core_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        KICK,
        WAIT_ACK,
        RUN,
        READ,
        DRAIN,
        DONE
    } host_state_e;

    // Offsets above the address field: inst[ADDR_W + INST_x]
    localparam int INST_LOAD  = 0;
    localparam int INST_PRD   = 1;
    localparam int INST_START = 2;
    localparam int INST_DEBUG = 3;

endpackage

// File: rtl/core_host_sequencer_fifo.sv
// rtl/core_host_sequencer_fifo.sv - two-entry readout FIFO between psum SRAM and the output stream
module host_out_fifo #(
    parameter int W = 104
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         out_valid,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         push_ok, pop_ok;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = pop && (count_q != 2'd0);
        // A full FIFO still accepts a push when the head leaves in the same cycle
        push_ok  = push && ((count_q != 2'd2) || pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign head      = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/core_host_sequencer.sv
// rtl/core_host_sequencer.sv - host initiator: x-mem load, core kick, busy tracking, psum readout stream
module core_host_sequencer
    import core_host_pkg::*;
#(
    parameter int bw          = 4,
    parameter int col         = 8,
    parameter int psum_bw     = 13,
    parameter int ADDR_W      = 11,
    parameter int inst_bw     = ADDR_W + 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      cfg_load_base,
    input  logic [ADDR_W-1:0]      cfg_load_count,
    input  logic [ADDR_W-1:0]      cfg_read_base,
    input  logic [ADDR_W-1:0]      cfg_read_count,
    input  logic [7:0]             cfg_num_nij,
    input  logic [7:0]             cfg_num_kij,
    input  logic [ADDR_W-1:0]      cfg_wt_addr,
    input  logic [ADDR_W-1:0]      cfg_act_addr,
    input  logic                   cfg_debug,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [bw*col-1:0]      in_data,
    output logic [inst_bw-1:0]     inst,
    output logic [bw*col-1:0]      D_xmem,
    output logic [7:0]             num_nij_to_compute,
    output logic [7:0]             num_kij_to_compute,
    output logic [ADDR_W-1:0]      weight_start_sram_addr,
    output logic [ADDR_W-1:0]      activation_start_sram_addr,
    input  logic                   core_busy,
    input  logic [psum_bw*col-1:0] psum_mem_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [psum_bw*col-1:0] out_data,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int AW_C = $clog2(ACK_TIMEOUT + 1);

    host_state_e         state_q, state_d;
    logic [ADDR_W-1:0]   load_base_q, load_base_d, load_cnt_q, load_cnt_d;
    logic [ADDR_W-1:0]   read_base_q, read_base_d, read_cnt_q, read_cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                debug_q, debug_d;
    logic [7:0]          nij_q, nij_d, kij_q, kij_d;
    logic [ADDR_W-1:0]   wt_q, wt_d, act_q, act_d;
    logic [AW_C-1:0]     ack_q, ack_d;
    logic [inst_bw-1:0]  inst_q, inst_d;
    logic [bw*col-1:0]   dx_q, dx_d;
    logic                err_q, err_d;
    logic                cap_q, cap_d;
    logic [1:0]          fifo_cnt;
    logic [1:0]          inflight;
    logic [2:0]          occupancy;

    // A read is in flight from issue until its SRAM word lands in the FIFO
    assign inflight  = {1'b0, inst_q[ADDR_W+INST_PRD]} + {1'b0, cap_q};
    assign occupancy = {1'b0, fifo_cnt} + {1'b0, inflight};

    always_comb begin
        state_d     = state_q;
        load_base_d = load_base_q;
        load_cnt_d  = load_cnt_q;
        read_base_d = read_base_q;
        read_cnt_d  = read_cnt_q;
        idx_d       = idx_q;
        debug_d     = debug_q;
        nij_d       = nij_q;
        kij_d       = kij_q;
        wt_d        = wt_q;
        act_d       = act_q;
        ack_d       = ack_q;
        dx_d        = dx_q;
        err_d       = err_q;
        inst_d      = '0;
        cap_d       = inst_q[ADDR_W+INST_PRD];

        case (state_q)
            IDLE: begin
                if (start) begin
                    load_base_d = cfg_load_base;
                    load_cnt_d  = cfg_load_count;
                    read_base_d = cfg_read_base;
                    read_cnt_d  = cfg_read_count;
                    debug_d     = cfg_debug;
                    nij_d       = cfg_num_nij;
                    kij_d       = cfg_num_kij;
                    wt_d        = cfg_wt_addr;
                    act_d       = cfg_act_addr;
                    err_d       = 1'b0;
                    idx_d       = '0;
                    state_d     = (cfg_load_count != '0) ? LOAD : KICK;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    inst_d[ADDR_W+INST_LOAD] = 1'b1;
                    inst_d[ADDR_W-1:0]       = load_base_q + idx_q;
                    dx_d                     = in_data;
                    idx_d                    = idx_q + ADDR_W'(1);
                    if (idx_q == load_cnt_q - ADDR_W'(1)) begin
                        state_d = KICK;
                    end
                end
            end
            KICK: begin
                inst_d[ADDR_W+INST_START] = 1'b1;
                ack_d                     = '0;
                state_d                   = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (core_busy) begin
                    state_d = RUN;
                end else if (ack_q == AW_C'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    ack_d = ack_q + AW_C'(1);
                end
            end
            RUN: begin
                if (!core_busy) begin
                    idx_d   = '0;
                    state_d = (read_cnt_q != '0) ? READ : DONE;
                end
            end
            READ: begin
                if (occupancy < 3'd2) begin
                    inst_d[ADDR_W+INST_PRD] = 1'b1;
                    inst_d[ADDR_W-1:0]      = read_base_q + idx_q;
                    idx_d                   = idx_q + ADDR_W'(1);
                    if (idx_q == read_cnt_q - ADDR_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (occupancy == 3'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        inst_d[ADDR_W+INST_DEBUG] = debug_d && (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            load_base_q <= '0;
            load_cnt_q  <= '0;
            read_base_q <= '0;
            read_cnt_q  <= '0;
            idx_q       <= '0;
            debug_q     <= 1'b0;
            nij_q       <= '0;
            kij_q       <= '0;
            wt_q        <= '0;
            act_q       <= '0;
            ack_q       <= '0;
            inst_q      <= '0;
            dx_q        <= '0;
            err_q       <= 1'b0;
            cap_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_base_q <= load_base_d;
            load_cnt_q  <= load_cnt_d;
            read_base_q <= read_base_d;
            read_cnt_q  <= read_cnt_d;
            idx_q       <= idx_d;
            debug_q     <= debug_d;
            nij_q       <= nij_d;
            kij_q       <= kij_d;
            wt_q        <= wt_d;
            act_q       <= act_d;
            ack_q       <= ack_d;
            inst_q      <= inst_d;
            dx_q        <= dx_d;
            err_q       <= err_d;
            cap_q       <= cap_d;
        end
    end

    host_out_fifo #(.W(psum_bw * col)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cap_q),
        .push_data (psum_mem_out),
        .pop       (out_valid && out_ready),
        .out_valid (out_valid),
        .head      (out_data),
        .count     (fifo_cnt)
    );

    assign in_ready                   = (state_q == LOAD);
    assign busy                       = (state_q != IDLE);
    assign done                       = (state_q == DONE);
    assign err                        = err_q;
    assign inst                       = inst_q;
    assign D_xmem                     = dx_q;
    assign num_nij_to_compute         = nij_q;
    assign num_kij_to_compute         = kij_q;
    assign weight_start_sram_addr     = wt_q;
    assign activation_start_sram_addr = act_q;

endmodule

// File: tb/tb_core_host_sequencer.sv
// tb/tb_core_host_sequencer.sv - scoreboard bench for core_host_sequencer with core and psum SRAM models
module tb_core_host_sequencer;

    localparam int AW  = 11;
    localparam int IBW = AW + 4;
    localparam int XW  = 32;
    localparam int PW  = 104;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] cfg_load_base, cfg_load_count, cfg_read_base, cfg_read_count;
    logic [7:0]    cfg_num_nij, cfg_num_kij;
    logic [AW-1:0] cfg_wt_addr, cfg_act_addr;
    logic          cfg_debug;
    logic          in_valid, in_ready;
    logic [XW-1:0] in_data;
    logic [IBW-1:0] inst;
    logic [XW-1:0] D_xmem;
    logic [7:0]    num_nij_to_compute, num_kij_to_compute;
    logic [AW-1:0] weight_start_sram_addr, activation_start_sram_addr;
    logic          core_busy;
    logic [PW-1:0] psum_mem_out;
    logic          out_valid, out_ready;
    logic [PW-1:0] out_data;
    logic          busy, done, err;

    core_host_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_load_base(cfg_load_base), .cfg_load_count(cfg_load_count),
        .cfg_read_base(cfg_read_base), .cfg_read_count(cfg_read_count),
        .cfg_num_nij(cfg_num_nij), .cfg_num_kij(cfg_num_kij),
        .cfg_wt_addr(cfg_wt_addr), .cfg_act_addr(cfg_act_addr), .cfg_debug(cfg_debug),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .inst(inst), .D_xmem(D_xmem),
        .num_nij_to_compute(num_nij_to_compute), .num_kij_to_compute(num_kij_to_compute),
        .weight_start_sram_addr(weight_start_sram_addr),
        .activation_start_sram_addr(activation_start_sram_addr),
        .core_busy(core_busy), .psum_mem_out(psum_mem_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc = 0, done_cnt = 0, rd_seen = 0, start_cnt = 0, start_cyc = 0, busy_fall_cyc = 0;
    int busy_dly = 2, busy_len = 3;
    bit first_rd = 1'b0;

    logic [AW+XW-1:0] exp_load[$];
    logic [AW-1:0]    exp_rd[$];
    logic [PW-1:0]    exp_out[$];
    bit               exp_done[$];

    logic [XW-1:0] words [8] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'hFFFF_FFFF,
                                 32'hDEAD_BEEF, 32'h0000_0001, 32'hA5A5_5A5A, 32'h8000_0000};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [PW-1:0] pword(input logic [AW-1:0] a);
        return {a, 82'h155_5555_5555_5555_5555, a};
    endfunction

    always @(posedge clk) cyc++;

    // Psum SRAM: one-cycle read latency
    always @(posedge clk) begin
        if (inst[AW+1]) psum_mem_out <= pword(inst[AW-1:0]);
    end

    // Core: raises busy busy_dly cycles after seeing start, holds busy_len cycles
    initial begin
        core_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && inst[AW+2] && busy_len > 0) begin
                repeat (busy_dly) @(negedge clk);
                core_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                core_busy = 1'b0;
                busy_fall_cyc = cyc;
            end
        end
    end

    always @(negedge clk) begin : monitor
        logic [AW+XW-1:0] le;
        logic [AW-1:0]    re;
        logic [PW-1:0]    oe;
        bit               de;
        #1;
        if (!reset) begin
            if (inst[AW]) begin
                check("load_prd_excl", 128'(inst[AW+2:AW+1]), 128'(0));
                check("load_q_nonempty", 128'(exp_load.size() != 0), 128'(1));
                if (exp_load.size() != 0) begin
                    le = exp_load.pop_front();
                    check("load_addr", 128'(inst[AW-1:0]), 128'(le[AW+XW-1:XW]));
                    check("load_data", 128'(D_xmem), 128'(le[XW-1:0]));
                end
            end
            if (inst[AW+1]) begin
                rd_seen++;
                check("rd_q_nonempty", 128'(exp_rd.size() != 0), 128'(1));
                if (exp_rd.size() != 0) begin
                    re = exp_rd.pop_front();
                    check("rd_addr", 128'(inst[AW-1:0]), 128'(re));
                end
                if (first_rd) begin
                    check("rd_latency_after_busy_fall", 128'(cyc - busy_fall_cyc), 128'(2));
                    first_rd = 1'b0;
                end
            end
            if (inst[AW+2]) begin
                start_cnt++;
                start_cyc = cyc;
                first_rd  = 1'b1;
            end
            if (out_valid && out_ready) begin
                check("out_q_nonempty", 128'(exp_out.size() != 0), 128'(1));
                if (exp_out.size() != 0) begin
                    oe = exp_out.pop_front();
                    check("out_data", 128'(out_data), 128'(oe));
                end
            end
            if (done) begin
                done_cnt++;
                check("done_q_nonempty", 128'(exp_done.size() != 0), 128'(1));
                if (exp_done.size() != 0) begin
                    de = exp_done.pop_front();
                    check("done_err", 128'(err), 128'(de));
                    if (de) check("timeout_cycles", 128'(cyc - start_cyc), 128'(16));
                end
                check("start_pulses_per_job", 128'(start_cnt), 128'(1));
                start_cnt = 0;
            end
        end
    end

    task automatic run_job(input logic [AW-1:0] lb, input logic [AW-1:0] lc,
                           input logic [AW-1:0] rb, input logic [AW-1:0] rc, input logic dbg);
        @(negedge clk);
        cfg_load_base = lb; cfg_load_count = lc; cfg_read_base = rb; cfg_read_count = rc;
        cfg_debug = dbg; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_words(input logic [AW-1:0] base, input int n, input int w0, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            while (!in_ready && t < 20) begin @(negedge clk); t++; end
            in_valid = 1'b1;
            in_data  = words[(w0 + i) % 8];
            exp_load.push_back({base + AW'(i), words[(w0 + i) % 8]});
            @(negedge clk);
            if (gaps) begin in_valid = 1'b0; @(negedge clk); end
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_reads(input logic [AW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(base + AW'(i));
            exp_out.push_back(pword(base + AW'(i)));
        end
    endtask

    task automatic wait_done(input int n);
        int t = 0;
        while (done_cnt < n && t < 400) begin @(negedge clk); t++; end
        check("done_within_budget", 128'(done_cnt >= n), 128'(1));
    endtask

    initial begin
        int r0;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_load_base = '0; cfg_load_count = '0; cfg_read_base = '0; cfg_read_count = '0;
        cfg_num_nij = 8'h21; cfg_num_kij = 8'h09; cfg_wt_addr = 11'h123; cfg_act_addr = 11'h456;
        cfg_debug = 1'b0; psum_mem_out = '0;
        repeat (2) @(negedge clk);
        check("rst_inst", 128'(inst), 128'(0));
        check("rst_dxmem", 128'(D_xmem), 128'(0));
        check("rst_flags", 128'({in_ready, out_valid, busy, done, err}), 128'(0));
        check("rst_out_data", 128'(out_data), 128'(0));
        check("rst_nij", 128'(num_nij_to_compute), 128'(0));
        reset = 1'b0;

        // 4-word continuous load at base 10, no readout
        busy_dly = 2; busy_len = 3;
        exp_done.push_back(1'b0);
        run_job(11'd10, 11'd4, 11'd0, 11'd0, 1'b1);
        check("cfg_nij", 128'(num_nij_to_compute), 128'(8'h21));
        check("cfg_kij", 128'(num_kij_to_compute), 128'(8'h09));
        check("cfg_addrs", 128'({weight_start_sram_addr, activation_start_sram_addr}), 128'({11'h123, 11'h456}));
        check("debug_bit", 128'(inst[AW+3]), 128'(1));
        send_words(11'd10, 4, 0, 1'b0);
        wait_done(1);

        // 3-word gapped load wrapping past 2047
        exp_done.push_back(1'b0);
        run_job(11'd2046, 11'd3, 11'd0, 11'd0, 1'b0);
        send_words(11'd2046, 3, 4, 1'b1);
        wait_done(2);
        check("debug_clear_idle", 128'(inst[AW+3]), 128'(0));

        // 5 reads at 2040 with readout stalled, plus an ignored start while busy
        busy_dly = 2; busy_len = 20; out_ready = 1'b0;
        expect_reads(11'd2040, 5);
        exp_done.push_back(1'b0);
        r0 = rd_seen;
        run_job(11'd0, 11'd0, 11'd2040, 11'd5, 1'b0);
        for (int t = 0; t < 100 && rd_seen < r0 + 1; t++) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        check("reads_while_stalled", 128'(rd_seen - r0), 128'(2));
        check("out_valid_stalled", 128'(out_valid), 128'(1));
        out_ready = 1'b1;
        wait_done(3);

        // Core never acknowledges
        busy_len = 0;
        exp_done.push_back(1'b1);
        run_job(11'd0, 11'd0, 11'd0, 11'd0, 1'b0);
        wait_done(4);
        check("timeout_busy_low", 128'(busy), 128'(0));
        check("timeout_err_set", 128'(err), 128'(1));

        // Next job clears err
        busy_dly = 3; busy_len = 4;
        expect_reads(11'd7, 1);
        exp_done.push_back(1'b0);
        run_job(11'd5, 11'd1, 11'd7, 11'd1, 1'b0);
        check("err_cleared_on_start", 128'(err), 128'(0));
        send_words(11'd5, 1, 6, 1'b0);
        wait_done(5);
        check("load_q_empty", 128'(exp_load.size()), 128'(0));
        check("out_q_empty", 128'(exp_out.size()), 128'(0));

        // Asynchronous reset while the FIFO holds two words
        busy_dly = 1; busy_len = 2; out_ready = 1'b0;
        expect_reads(11'd300, 5);
        r0 = rd_seen;
        run_job(11'd0, 11'd0, 11'd300, 11'd5, 1'b0);
        for (int t = 0; t < 100 && rd_seen < r0 + 2; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("fifo_full_before_reset", 128'(out_valid), 128'(1));
        #2 reset = 1'b1;
        #1;
        check("async_rst_out_valid", 128'(out_valid), 128'(0));
        check("async_rst_inst", 128'(inst), 128'(0));
        check("async_rst_busy", 128'(busy), 128'(0));
        exp_rd.delete(); exp_out.delete(); exp_load.delete(); exp_done.delete();
        start_cnt = 0; first_rd = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_reset", 128'({busy, out_valid, inst}), 128'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/core_host_sequencer.md
Name: core_host_sequencer

Overview:
Host-side initiator that drives the core's instruction and configuration interface, replacing testbench-driven stimulus. It streams activation/weight words into x-mem, pulses start_controller, tracks core_busy until the core finishes, then issues psum-memory reads and returns the results on a valid/ready output stream. It sits between a host/DMA stream and the core instance.

Parameters:
bw, 4, activation bit-width
col, 8, PE columns (x-mem word = bw*col, psum word = psum_bw*col)
psum_bw, 13, partial-sum bit-width
ADDR_W, 11, SRAM address width
inst_bw, ADDR_W+4, instruction width
ACK_TIMEOUT, 16, max cycles from start pulse to core_busy high

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle job start; sampled only in IDLE
cfg_load_base  in  ADDR_W  first x-mem address to write
cfg_load_count  in  ADDR_W  x-mem words to write (0 = skip load)
cfg_read_base  in  ADDR_W  first psum address to read
cfg_read_count  in  ADDR_W  psum words to read (0 = skip readout)
cfg_num_nij  in  8  forwarded to core num_nij_to_compute
cfg_num_kij  in  8  forwarded to core num_kij_to_compute
cfg_wt_addr  in  ADDR_W  forwarded weight_start_sram_addr
cfg_act_addr  in  ADDR_W  forwarded activation_start_sram_addr
cfg_debug  in  1  drives inst[ADDR_W+3] for the whole job
in_valid  in  1  x-mem data valid
in_ready  out  1  sequencer accepts x-mem word
in_data  in  bw*col  x-mem word
inst  out  inst_bw  instruction packet to core
D_xmem  out  bw*col  x-mem write data
num_nij_to_compute  out  8  registered cfg
num_kij_to_compute  out  8  registered cfg
weight_start_sram_addr  out  ADDR_W  registered cfg
activation_start_sram_addr  out  ADDR_W  registered cfg
core_busy  in  1  core controller active
psum_mem_out  in  psum_bw*col  psum SRAM Q
out_valid  out  1  readout word valid
out_ready  in  1  downstream accepts
out_data  out  psum_bw*col  readout word
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at job end
err  out  1  sticky ack-timeout flag; cleared by next accepted start

Behaviour:
- Reset (async): state IDLE; inst=0, D_xmem=0, cfg outputs=0, in_ready=0, out_valid=0, out_data=0, busy=0, done=0, err=0; counters and FIFO cleared. Reset mid-job aborts immediately, no cleanup cycles.
- inst fields: [ADDR_W+3] debug, [ADDR_W+2] start_controller, [ADDR_W+1] psum read enable, [ADDR_W] x-mem load, [ADDR_W-1:0] address. All inst bits registered.
- IDLE: on start, latch all cfg, clear err -> LOAD (count!=0) else KICK.
- LOAD: in_ready=1. Each in_valid&in_ready registers inst load bit=1, addr=base+i, D_xmem=in_data next cycle; no beat -> load bit 0. After count beats -> KICK. Address wraps mod 2^ADDR_W.
- KICK: inst start bit high exactly one cycle -> WAIT_ACK.
- WAIT_ACK: core_busy=1 -> RUN. After ACK_TIMEOUT cycles without it: set err, pulse done, -> IDLE.
- RUN: wait core_busy=0 -> READ (count!=0) else DONE.
- READ: issue read (psum bit=1, addr=base+j) only when FIFO occupancy + in-flight < 2. SRAM latency 1 cycle: psum_mem_out captured into 2-entry FIFO the cycle after issue. All issued -> DRAIN.
- DRAIN: wait FIFO empty and nothing in flight -> DONE.
- Output FIFO: out_valid = not empty; out_data = head; simultaneous push and pop allowed at occupancy 1 or 2 (count unchanged). Order preserved.
- DONE: done=1 one cycle -> IDLE. start during non-IDLE ignored.
- Never assert load and psum bits together; start bit only in KICK.

Decomposition:
- Package core_host_pkg: state enum (IDLE, LOAD, KICK, WAIT_ACK, RUN, READ, DRAIN, DONE), inst bit-position constants (INST_DEBUG, INST_START, INST_PRD, INST_LOAD).
- Sub-module: host_out_fifo (2-entry, psum_bw*col wide, push/pop/count).

Test Plan:
- load_count=4, base=10, in_valid continuous -> inst load bit high 4 cycles, addr 10..13, D_xmem matches inputs in order.
- in_valid toggles 1-0-1-0 during 3-word load -> exactly 3 writes, no write on gap cycles, addresses contiguous.
- Core model raises core_busy 2 cycles after start bit, holds 20 cycles -> single start pulse, READ entered the cycle after busy falls.
- read_count=5, base=2040 (ADDR_W=11), out_ready stuck low 10 cycles -> only 2 reads issued, addresses 2040..2044 wrap to 0 after 2047 not reached; then all 5 words delivered in order, done pulses once.
- core_busy never rises -> err=1 and done after 16 cycles, busy=0; next start clears err.
- Reset asserted in READ with FIFO holding 2 -> out_valid=0, inst=0, state IDLE immediately (asynchronously).
